// File: rtl/irq_controller.sv
// irq_controller: eight-line edge-latched interrupt controller with nesting.
// Optional input synchronizer enabled by defining IRQ_SYNC_EN.
module irq_controller #(
  parameter logic [4:0] VECTOR_BASE = 5'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic [7:0] mask_q,
  output logic       irq_req,
  output logic [7:0] irq_vec,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic [7:0] in_service
);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       irq_req_q, irq_req_d;
  logic [7:0] irq_vec_q, irq_vec_d;
  logic [7:0] mask_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] in_service_q, in_service_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] edge_src;
  logic [7:0] rise;
  logic [7:0] above;
  logic [7:0] eligible;
  logic [7:0] ack_clr;
  logic [7:0] eoi_clr;
  logic [2:0] top_is;
  logic       is_any;

  // Highest set bit wins; bit 7 is the top priority.
  function automatic logic [2:0] priority_encoder(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

`ifdef IRQ_SYNC_EN
  logic [7:0] sync1_q, sync1_d;
  logic [7:0] sync2_q, sync2_d;

  // Two-flop synchronizer stages for the asynchronous request lines.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign edge_src = sync2_q;
`else
  assign edge_src = irq_in;
`endif

  // Edge detect plus in-service level and eligibility.
  always_comb begin
    prev_d   = edge_src;
    rise     = edge_src & ~prev_q;
    is_any   = |in_service_q;
    top_is   = priority_encoder(in_service_q);
    above    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      above[i] = !is_any || (i > int'(top_is));
    end
    eligible = pending_q & ~mask_q & above;
  end

  // Handshake FSM next state and pending/in-service updates.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    irq_req_d = irq_req_q;
    irq_vec_d = irq_vec_q;
    ack_clr   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (|eligible) begin
          idx_d     = priority_encoder(eligible);
          irq_vec_d = {VECTOR_BASE, idx_d};
          irq_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          ack_clr   = 8'(1) << idx_q;
          irq_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase
    // A rise in the ack cycle re-arms the line.
    pending_d    = (pending_q & ~ack_clr) | rise;
    // eoi retires the pre-edge top level before the ack is recorded.
    eoi_clr      = (eoi && is_any) ? (8'(1) << top_is) : 8'h00;
    in_service_d = (in_service_q & ~eoi_clr) | ack_clr;
    mask_d       = mask_wr ? mask_data : mask_q;
  end

  // All controller state; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      irq_req_q    <= 1'b0;
      irq_vec_q    <= 8'h00;
      mask_q       <= 8'hFF;
      pending_q    <= 8'h00;
      in_service_q <= 8'h00;
      prev_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      irq_req_q    <= irq_req_d;
      irq_vec_q    <= irq_vec_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      prev_q       <= prev_d;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_vec    = irq_vec_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed checks of irq_controller.
// Expected values are hand-computed from the controller behaviour.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
  localparam int LATR = 3;
`else
  localparam int LATR = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic [7:0] mask_q;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic       irq_ack;
  logic       eoi;
  logic [7:0] in_service;

  int total;
  int bad;

  irq_controller #(
    .VECTOR_BASE(5'd0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .mask_q    (mask_q),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .in_service(in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    irq_in    = 8'h00;
    mask_wr   = 1'b0;
    mask_data = 8'h00;
    irq_ack   = 1'b0;
    eoi       = 1'b0;
    tick(3);
    check("rst_mask", mask_q, 8'hFF);
    check("rst_is", in_service, 8'h00);
    check("rst_req", {7'd0, irq_req}, 8'h00);
    check("rst_vec", irq_vec, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // basic request on line 3
    mask_wr   = 1'b1;
    mask_data = 8'h00;
    tick(1);
    mask_wr = 1'b0;
    check("mask_wr", mask_q, 8'h00);
    irq_in = 8'h08;
    tick(LATR);
    check("lat_early", {7'd0, irq_req}, 8'h00);
    tick(1);
    check("lat_req", {7'd0, irq_req}, 8'h01);
    check("vec3", irq_vec, 8'h03);
    irq_in = 8'h00;
    do_ack();
    check("ack3_req", {7'd0, irq_req}, 8'h00);
    check("ack3_is", in_service, 8'h08);
    do_eoi();
    check("eoi3_is", in_service, 8'h00);

    // simultaneous lines 2 and 6
    irq_in = 8'h44;
    tick(LATR + 1);
    check("vec6", irq_vec, 8'h06);
    irq_in = 8'h00;
    do_ack();
    check("ack6_is", in_service, 8'h40);
    tick(1);
    check("l2_blocked", {7'd0, irq_req}, 8'h00);
    do_eoi();
    check("eoi6_req", {7'd0, irq_req}, 8'h00);
    tick(1);
    check("vec2_req", {7'd0, irq_req}, 8'h01);
    check("vec2", irq_vec, 8'h02);
    do_ack();
    check("ack2_is", in_service, 8'h04);
    do_eoi();

    // nesting under line 3
    irq_in = 8'h08;
    tick(LATR + 1);
    check("n_vec3", irq_vec, 8'h03);
    irq_in = 8'h00;
    do_ack();
    irq_in = 8'h22;
    tick(LATR + 1);
    check("n_vec5", irq_vec, 8'h05);
    irq_in = 8'h00;
    do_ack();
    check("n_is28", in_service, 8'h28);
    tick(2);
    check("n_l1_wait", {7'd0, irq_req}, 8'h00);
    do_eoi();
    check("n_is08", in_service, 8'h08);
    tick(1);
    check("n_l1_wait2", {7'd0, irq_req}, 8'h00);
    do_eoi();
    check("n_l1_wait3", {7'd0, irq_req}, 8'h00);
    tick(1);
    check("n_vec1", irq_vec, 8'h01);
    check("n_req1", {7'd0, irq_req}, 8'h01);
    do_ack();
    check("n_is02", in_service, 8'h02);
    do_eoi();

    // masking
    mask_wr   = 1'b1;
    mask_data = 8'h80;
    tick(1);
    mask_wr = 1'b0;
    irq_in  = 8'h80;
    tick(LATR + 3);
    check("m_none", {7'd0, irq_req}, 8'h00);
    irq_in    = 8'h00;
    mask_wr   = 1'b1;
    mask_data = 8'h00;
    tick(1);
    mask_wr = 1'b0;
    check("m_oldmask", {7'd0, irq_req}, 8'h00);
    tick(1);
    check("m_req", {7'd0, irq_req}, 8'h01);
    check("m_vec7", irq_vec, 8'h07);
    do_ack();
    do_eoi();

    // eoi+ack together, rise during ack
    irq_in = 8'h10;
    tick(LATR + 1);
    check("e_vec4", irq_vec, 8'h04);
    irq_in = 8'h00;
    do_ack();
    check("e_is10", in_service, 8'h10);
    irq_in = 8'h40;
    tick(LATR + 1);
    check("e_vec6", irq_vec, 8'h06);
    irq_in = 8'h00;
    tick(3);
    check("e_hold", {7'd0, irq_req}, 8'h01);
    irq_in = 8'h40;
    tick(LATR - 1);
    irq_ack = 1'b1;
    eoi     = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    eoi     = 1'b0;
    check("e_is40", in_service, 8'h40);
    check("e_req0", {7'd0, irq_req}, 8'h00);
    do_eoi();
    check("e_is0", in_service, 8'h00);
    tick(1);
    check("e_re6_req", {7'd0, irq_req}, 8'h01);
    check("e_re6_vec", irq_vec, 8'h06);
    do_ack();
    do_eoi();
    tick(4);
    check("e_level", {7'd0, irq_req}, 8'h00);
    irq_in = 8'h00;
    tick(3);

    // asynchronous reset mid-handshake
    irq_in = 8'h08;
    tick(LATR + 1);
    check("r_req", {7'd0, irq_req}, 8'h01);
    #2;
    rst_n  = 1'b0;
    irq_in = 8'h00;
    #1;
    check("r_async", {7'd0, irq_req}, 8'h00);
    check("r_is", in_service, 8'h00);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("r_mask", mask_q, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Eight-line interrupt controller that latches request edges, masks them, selects the highest-priority eligible line, and hands it to the consumer with a req/ack handshake. It sits downstream of the raw request sources and upstream of the core's trap logic. Internally it uses a priority_encoder (bit 7 highest) and tracks in-service levels so that only strictly higher-priority interrupts can nest.

## Interface
- VECTOR_BASE, default 5'd0: upper 5 bits of the emitted vector.

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; **one clock; reset is asynchronous and active-low**.
- irq_in  input  8  raw request lines, asynchronous to clk; a rising edge raises a request.
- mask_wr  input  1  write strobe for the mask register.
- mask_data  input  8  new mask value; 1 = line masked.
- mask_q  output  8  current mask register.
- irq_req  output  1  interrupt request to the consumer.
- irq_vec  output  8  {VECTOR_BASE, idx[2:0]}; stable while irq_req=1.
- irq_ack  input  1  consumer accepts the presented vector.
- eoi  input  1  end-of-interrupt; retires the highest in-service level.
- in_service  output  8  in-service register.

## Operation
- Input path: per-line 2-flop synchronizer, then a register holding the previous synchronized value; rise = sync & ~prev.
- pending[i] set on rise[i]; cleared only by acknowledging line i. Pending bits latch regardless of mask.
- top_is = index of highest set in_service bit, or "none".
- eligible = pending & ~mask_q & lines with index > top_is; all lines are above top_is when in_service == 0.
- FSM, 2 states:
  - IDLE: irq_req=0. If eligible != 0, capture idx = priority_encoder(eligible) into a register and go to REQ.
  - REQ: irq_req=1, irq_vec = {VECTOR_BASE, idx}. When irq_ack=1: clear pending[idx], set in_service[idx], go to IDLE.
- No preemption in REQ: a higher-priority arrival waits until the current handshake completes, then is presented from IDLE.
- irq_ack in IDLE is ignored.
- eoi clears the highest set in_service bit; with in_service == 0 it is a no-op.
- mask_wr loads mask_q on the next edge. It does not withdraw a request already in REQ.

## Timing
- Reset values: mask_q = 8'hFF, pending = 0, in_service = 0, irq_req = 0, irq_vec = 8'h00, state = IDLE, synchronizer and prev flops = 0.
- Latency: irq_in high at sampling edge N -> pending set after edge N+2 -> irq_req=1 after edge N+3.
- irq_ack sampled at edge M: irq_req=0 after M, in_service updated after M.
  - The earliest next request, if another line is eligible, is irq_req=1 after edge M+1. There is always at least one cycle low between handshakes.
- Same-line rise and ack-clear in the same cycle: set wins, and pending stays 1.
- eoi and irq_ack in the same cycle:
  - eoi clears the highest bit of the pre-edge in_service.
  - The ack set is applied afterward.
  - The new in_service = (old with top bit cleared) | (1 << idx).
- A mask write in the same cycle as the IDLE evaluation: evaluation uses the old mask_q.
- A level held high produces one request only; the line must fall and rise again to request again.
- Reset asserted mid-handshake: all state clears immediately (asynchronously) and irq_req drops without waiting for clk.

## Configuration
- IRQ_SYNC_EN defined: the 2-flop synchronizer is present, with latency as above.
- IRQ_SYNC_EN undefined: the synchronizer is removed and the edge detect uses irq_in directly. irq_in must then be synchronous to clk.
  - Latency becomes: rise sampled at edge N -> pending set after N -> irq_req=1 after N+1.
  - All other behaviour is identical.

## Test plan
- Reset, then mask_data=8'h00 via mask_wr, then pulse irq_in[3] -> irq_req=1 three edges after sampling, irq_vec=8'h03; ack -> in_service=8'h08, irq_req=0.
- Rise irq_in[2] and irq_in[6] in the same cycle -> vec 8'h06 first; ack, then eoi -> vec 8'h02 presented next.
- Nesting: in_service=8'h08 (line 3), raise lines 1 and 5 -> only 5 is presented; after ack in_service=8'h28, and line 1 stays pending until two eoi pulses.
- Mask: mask_q=8'h80, raise line 7 -> no irq_req; write mask 8'h00 -> request appears on the following IDLE evaluation with vec 8'h07.
- Simultaneous eoi+ack with in_service=8'h10 and idx=6 -> in_service=8'h40. A fresh rise on line 6 during its ack -> pending[6] remains 1.
- Assert rst_n=0 while irq_req=1 -> irq_req=0 with no clock edge, and mask_q reads 8'hFF after release.
